serial_parity_checker: RTL and testbench

Serial stage that consumes a stream of single-bit results and folds them into a running XOR. After FRAME_LEN data bits it accepts one parity bit, checks it, and reports pass/fail through a valid/ready output handshake. It also keeps a saturating count of failed frames. It sits directly downstream of the 2-input XOR gate cells and is the team's first clocked checker stage.

---
 rtl/serial_parity_pkg.sv | 16 +
 rtl/sat_counter.sv | 26 ++
 rtl/serial_parity_checker.sv | 101 ++++++++++
 tb/tb_serial_parity_checker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity checker: FSM encoding,
// default error-counter width and the bit-counter width helper.
package serial_parity_pkg;

   localparam logic [1:0] ST_DATA   = 2'd0;
   localparam logic [1:0] ST_PARITY = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   localparam int ERR_W_DEF = 8;

   // Index counter width; never narrower than one bit, even for one-bit frames.
   function automatic int cnt_width(input int frame_len);
      return (frame_len <= 2) ? 1 : $clog2(frame_len);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         reset,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (reset) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/serial_parity_checker.sv
// Folds a serial bit stream into a running XOR, checks the trailing parity
// bit of each frame and hands the verdict out over a valid/ready handshake.
module serial_parity_checker
   import serial_parity_pkg::*;
#(
   parameter int   FRAME_LEN = 8,
   parameter logic ODD       = 1'b0,
   parameter int   ERR_W     = ERR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   output logic             parity_err,
   input  logic             out_ready,
   output logic [ERR_W-1:0] err_count
);

   localparam int            CW       = cnt_width(FRAME_LEN);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_acc;
   logic          r_out_valid;
   logic          r_parity_err;

   logic w_xfer;
   logic w_err_now;
   logic w_err_inc;

   // in_ready depends on state only, so no input ever reaches it combinationally.
   assign in_ready  = (r_state == ST_DATA) || (r_state == ST_PARITY);
   assign w_xfer    = in_valid && in_ready;
   assign w_err_now = r_acc ^ in_bit;
   assign w_err_inc = !clear && w_xfer && (r_state == ST_PARITY) && w_err_now;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_DATA;
         r_cnt        <= '0;
         r_acc        <= ODD;
         r_out_valid  <= 1'b0;
         r_parity_err <= 1'b0;
      end else if (clear) begin
         r_state      <= ST_DATA;
         r_cnt        <= '0;
         r_acc        <= ODD;
         r_out_valid  <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         case (r_state)
            ST_DATA: begin
               if (w_xfer) begin
                  r_acc <= w_err_now;
                  if (r_cnt == LAST_IDX) begin
                     r_cnt   <= '0;
                     r_state <= ST_PARITY;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_xfer) begin
                  r_parity_err <= w_err_now;
                  r_out_valid  <= 1'b1;
                  r_state      <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               // Verdict is held until the consumer takes it; the accumulator
               // is re-seeded here so the next frame starts clean.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_acc       <= ODD;
                  r_state     <= ST_DATA;
               end
            end
            default: r_state <= ST_DATA;
         endcase
      end
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_err_inc),
      .reset (1'b0),
      .count (err_count)
   );

   assign out_valid  = r_out_valid;
   assign parity_err = r_parity_err;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: three instances (even/8, odd/8, even/1)
// share one stimulus stream; verdicts are checked against a result queue.
module tb_serial_parity_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic out_ready = 1'b0;

   logic       ir_a, ov_a, pe_a;
   logic       ir_b, ov_b, pe_b;
   logic       ir_c, ov_c, pe_c;
   logic [7:0] ec_a, ec_b, ec_c;

   bit qa[$];
   bit qb[$];
   bit qc[$];
   int exp_cnt_a = 0;
   int exp_cnt_b = 0;
   int exp_cnt_c = 0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_parity_checker #(.FRAME_LEN(8), .ODD(1'b0), .ERR_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(ir_a), .out_valid(ov_a), .parity_err(pe_a), .out_ready(out_ready),
      .err_count(ec_a));

   serial_parity_checker #(.FRAME_LEN(8), .ODD(1'b1), .ERR_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(ir_b), .out_valid(ov_b), .parity_err(pe_b), .out_ready(out_ready),
      .err_count(ec_b));

   serial_parity_checker #(.FRAME_LEN(1), .ODD(1'b0), .ERR_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(ir_c), .out_valid(ov_c), .parity_err(pe_c), .out_ready(out_ready),
      .err_count(ec_c));

   task automatic send_bit(input logic b);
      in_valid = 1'b1;
      in_bit   = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Sends data[len-1] first, then the parity bit, and queues the verdicts.
   task automatic send_frame(input logic [7:0] data, input int len, input logic par,
                             input bit to_c);
      logic x;
      x = 1'b0;
      for (int i = len - 1; i >= 0; i--) begin
         send_bit(data[i]);
         x = x ^ data[i];
      end
      send_bit(par);
      if (to_c) begin
         qc.push_back(x ^ par);
         if ((x ^ par) && exp_cnt_c < 255) exp_cnt_c++;
      end else begin
         qa.push_back(x ^ par);
         qb.push_back(x ^ par ^ 1'b1);
         if ((x ^ par) && exp_cnt_a < 255) exp_cnt_a++;
         if (!(x ^ par) && exp_cnt_b < 255) exp_cnt_b++;
      end
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bit ok;
      @(negedge clk);
      n_checks++;
      ok = (ov_a === 1'b0) && (pe_a === 1'b0) && (ec_a === 8'd0) && (ir_a === 1'b1);
      if (!ok) $display("FAIL reset_a: ov=%b pe=%b ec=%0d ir=%b want 0 0 0 1", ov_a, pe_a, ec_a, ir_a);
      else n_pass++;
      n_checks++;
      ok = (ov_b === 1'b0) && (ec_b === 8'd0) && (ov_c === 1'b0) && (ir_c === 1'b1);
      if (!ok) $display("FAIL reset_bc: ov_b=%b ec_b=%0d ov_c=%b ir_c=%b want 0 0 0 1", ov_b, ec_b, ov_c, ir_c);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_good_frame();
      bit ea, eb;
      send_frame(8'b1011_0010, 8, 1'b0, 1'b0);
      @(negedge clk);
      ea = qa.pop_front();
      eb = qb.pop_front();
      n_checks++;
      if (ov_a !== 1'b1 || pe_a !== ea) $display("FAIL good_a: ov=%b pe=%b want 1 %b", ov_a, pe_a, ea);
      else n_pass++;
      n_checks++;
      if (ov_b !== 1'b1 || pe_b !== eb) $display("FAIL good_b: ov=%b pe=%b want 1 %b", ov_b, pe_b, eb);
      else n_pass++;
      n_checks++;
      if (ec_a !== 8'(exp_cnt_a)) $display("FAIL good_cnt: ec=%0d want %0d", ec_a, exp_cnt_a);
      else n_pass++;
      ack();
      n_checks++;
      if (ov_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL good_ack: ov=%b ir=%b want 0 1", ov_a, ir_a);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit ea, eb;
      send_frame(8'b1011_0010, 8, 1'b1, 1'b0);
      @(negedge clk);
      ea = qa.pop_front();
      eb = qb.pop_front();
      n_checks++;
      if (ov_a !== 1'b1 || pe_a !== ea) $display("FAIL bad_a: ov=%b pe=%b want 1 %b", ov_a, pe_a, ea);
      else n_pass++;
      n_checks++;
      if (ec_a !== 8'(exp_cnt_a)) $display("FAIL bad_cnt: ec=%0d want %0d", ec_a, exp_cnt_a);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_bit   = i[0];
         @(negedge clk);
         n_checks++;
         if (ov_a !== 1'b1 || ir_a !== 1'b0 || pe_a !== ea)
            $display("FAIL hold_%0d: ov=%b ir=%b pe=%b want 1 0 %b", i, ov_a, ir_a, pe_a, ea);
         else n_pass++;
      end
      in_valid = 1'b0;
      ack();
      n_checks++;
      if (ov_a !== 1'b0) $display("FAIL hold_ack: ov=%b want 0", ov_a);
      else n_pass++;
      send_frame(8'b1011_0010, 8, 1'b0, 1'b0);
      @(negedge clk);
      ea = qa.pop_front();
      eb = qb.pop_front();
      n_checks++;
      if (ov_a !== 1'b1 || pe_a !== ea || ec_a !== 8'(exp_cnt_a))
         $display("FAIL after_hold: ov=%b pe=%b ec=%0d want 1 %b %0d", ov_a, pe_a, ec_a, ea, exp_cnt_a);
      else n_pass++;
      ack();
   endtask

   task automatic test_odd();
      bit ea, eb;
      for (int p = 0; p < 2; p++) begin
         send_frame(8'b0000_0001, 8, p[0], 1'b0);
         @(negedge clk);
         ea = qa.pop_front();
         eb = qb.pop_front();
         n_checks++;
         if (ov_b !== 1'b1 || pe_b !== eb) $display("FAIL odd_b_p%0d: ov=%b pe=%b want 1 %b", p, ov_b, pe_b, eb);
         else n_pass++;
         n_checks++;
         if (pe_a !== ea || ec_b !== 8'(exp_cnt_b))
            $display("FAIL odd_a_p%0d: pe_a=%b ec_b=%0d want %b %0d", p, pe_a, ec_b, ea, exp_cnt_b);
         else n_pass++;
         ack();
      end
   endtask

   task automatic test_async_reset();
      bit ea, eb, ok;
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_cnt_a = 0;
      exp_cnt_b = 0;
      exp_cnt_c = 0;
      n_checks++;
      ok = (ov_a === 1'b0) && (pe_a === 1'b0) && (ir_a === 1'b1) && (ec_a === 8'd0) && (ec_b === 8'd0);
      if (!ok) $display("FAIL arst: ov=%b pe=%b ir=%b ec_a=%0d ec_b=%0d want 0 0 1 0 0", ov_a, pe_a, ir_a, ec_a, ec_b);
      else n_pass++;
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_frame(8'b1100_0000, 8, 1'b0, 1'b0);
      @(negedge clk);
      ea = qa.pop_front();
      eb = qb.pop_front();
      n_checks++;
      if (ov_a !== 1'b1 || pe_a !== ea) $display("FAIL arst_frame: ov=%b pe=%b want 1 %b", ov_a, pe_a, ea);
      else n_pass++;
      ack();
   endtask

   task automatic test_clear();
      bit ea, eb;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      send_frame(8'b1011_0010, 8, 1'b0, 1'b0);
      @(negedge clk);
      ea = qa.pop_front();
      eb = qb.pop_front();
      n_checks++;
      if (ov_a !== 1'b1 || pe_a !== ea || ec_a !== 8'(exp_cnt_a))
         $display("FAIL clear_frame: ov=%b pe=%b ec=%0d want 1 %b %0d", ov_a, pe_a, ec_a, ea, exp_cnt_a);
      else n_pass++;
      // Abort while a verdict is pending: result dropped, counts kept.
      clear     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      clear     = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (ov_a !== 1'b0 || pe_a !== 1'b0 || ir_a !== 1'b1 || ec_b !== 8'(exp_cnt_b))
         $display("FAIL clear_report: ov=%b pe=%b ir=%b ec_b=%0d want 0 0 1 %0d", ov_a, pe_a, ir_a, ec_b, exp_cnt_b);
      else n_pass++;
   endtask

   task automatic test_saturation();
      bit ea, eb;
      for (int f = 0; f < 260; f++) begin
         send_frame(8'h00, 8, 1'b1, 1'b0);
         @(negedge clk);
         ea = qa.pop_front();
         eb = qb.pop_front();
         n_checks++;
         if (ov_a !== 1'b1 || pe_a !== ea || pe_b !== eb)
            $display("FAIL sat_frame_%0d: ov=%b pe_a=%b pe_b=%b want 1 %b %b", f, ov_a, pe_a, pe_b, ea, eb);
         else n_pass++;
         ack();
      end
      n_checks++;
      if (ec_a !== 8'(exp_cnt_a) || exp_cnt_a != 255) $display("FAIL sat_cnt: ec=%0d want %0d", ec_a, exp_cnt_a);
      else n_pass++;
      send_frame(8'h00, 8, 1'b1, 1'b0);
      @(negedge clk);
      ea = qa.pop_front();
      eb = qb.pop_front();
      n_checks++;
      if (ec_a !== 8'd255 || pe_a !== ea) $display("FAIL sat_hold: ec=%0d pe=%b want 255 %b", ec_a, pe_a, ea);
      else n_pass++;
      n_checks++;
      if (ec_b !== 8'(exp_cnt_b)) $display("FAIL sat_cnt_b: ec=%0d want %0d", ec_b, exp_cnt_b);
      else n_pass++;
      ack();
   endtask

   task automatic test_frame_len1();
      bit ec;
      #2;
      rst_n = 1'b0;
      #1;
      exp_cnt_a = 0;
      exp_cnt_b = 0;
      exp_cnt_c = 0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int p = 1; p >= 0; p--) begin
         send_frame(8'h01, 1, p[0], 1'b1);
         @(negedge clk);
         ec = qc.pop_front();
         n_checks++;
         if (ov_c !== 1'b1 || pe_c !== ec) $display("FAIL len1_p%0d: ov=%b pe=%b want 1 %b", p, ov_c, pe_c, ec);
         else n_pass++;
         ack();
      end
      n_checks++;
      if (ec_c !== 8'(exp_cnt_c)) $display("FAIL len1_cnt: ec=%0d want %0d", ec_c, exp_cnt_c);
      else n_pass++;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      test_reset();
      test_good_frame();
      test_backpressure();
      test_odd();
      test_async_reset();
      test_clear();
      test_saturation();
      test_frame_len1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
